// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: independent round-robin write/read arbitration of N_REQ clients onto one simple dual-port RAM
module ram_rr_arbiter #(
    parameter int MEM_WIDTH = 8,
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = $clog2(MEM_DEPTH),
    parameter int N_REQ     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           wr_req,
    input  logic [N_REQ*ADDR_SIZE-1:0] wr_addr,
    input  logic [N_REQ*MEM_WIDTH-1:0] wr_data,
    output logic [N_REQ-1:0]           wr_gnt,
    input  logic [N_REQ-1:0]           rd_req,
    input  logic [N_REQ*ADDR_SIZE-1:0] rd_addr,
    output logic [N_REQ-1:0]           rd_gnt,
    output logic [N_REQ-1:0]           rd_valid,
    output logic [MEM_WIDTH-1:0]       rd_data,
    output logic                       ram_wr_en,
    output logic [ADDR_SIZE-1:0]       ram_addr_wr,
    output logic [MEM_WIDTH-1:0]       ram_din,
    output logic                       ram_rd_en,
    output logic [ADDR_SIZE-1:0]       ram_addr_rd,
    input  logic [MEM_WIDTH-1:0]       ram_dout
);
    localparam int PW = $clog2(N_REQ);

    logic [PW-1:0] wr_ptr, rd_ptr;

    // search begins just after the last winner, so that winner ends up lowest priority
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req, input logic [PW-1:0] ptr);
        logic [N_REQ-1:0] g;
        logic found;
        logic [PW-1:0] idx;
        g = '0;
        found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [PW-1:0] enc(input logic [N_REQ-1:0] g);
        logic [PW-1:0] e;
        e = '0;
        for (int i = 0; i < N_REQ; i++)
            if (g[i]) e = PW'(i);
        return e;
    endfunction

    always_comb begin
        wr_gnt      = rst ? '0 : rr_pick(wr_req, wr_ptr);
        rd_gnt      = rst ? '0 : rr_pick(rd_req, rd_ptr);
        ram_addr_wr = '0;
        ram_din     = '0;
        ram_addr_rd = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (wr_gnt[i]) begin
                ram_addr_wr = wr_addr[i*ADDR_SIZE +: ADDR_SIZE];
                ram_din     = wr_data[i*MEM_WIDTH +: MEM_WIDTH];
            end
            if (rd_gnt[i]) ram_addr_rd = rd_addr[i*ADDR_SIZE +: ADDR_SIZE];
        end
    end

    assign ram_wr_en = |wr_gnt;
    assign ram_rd_en = |rd_gnt;
    assign rd_data   = ram_dout;

    // rd_valid doubles as the read-pending flag: it marks which client owns ram_dout this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= PW'(N_REQ - 1);
            rd_ptr   <= PW'(N_REQ - 1);
            rd_valid <= '0;
        end else begin
            if (|wr_gnt) wr_ptr <= enc(wr_gnt);
            if (|rd_gnt) rd_ptr <= enc(rd_gnt);
            rd_valid <= rd_gnt;
        end
    end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed and random checks of ram_rr_arbiter against a pointer/array reference model
module tb_ram_rr_arbiter;
    localparam int N = 4;
    localparam int AW = 8;
    localparam int MW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    wr_req = '0, rd_req = '0;
    logic [N*AW-1:0] wr_addr = '0, rd_addr = '0;
    logic [N*MW-1:0] wr_data = '0;
    logic [N-1:0]    wr_gnt, rd_gnt, rd_valid;
    logic [MW-1:0]   rd_data, ram_din, ram_dout;
    logic [AW-1:0]   ram_addr_wr, ram_addr_rd;
    logic            ram_wr_en, ram_rd_en;

    ram_rr_arbiter #(.MEM_WIDTH(MW), .MEM_DEPTH(256), .N_REQ(N)) dut (
        .clk(clk), .rst(rst),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .ram_wr_en(ram_wr_en), .ram_addr_wr(ram_addr_wr), .ram_din(ram_din),
        .ram_rd_en(ram_rd_en), .ram_addr_rd(ram_addr_rd), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // RAM attached to the arbiter: registered read, read-before-write on collision
    logic [MW-1:0] mem [256];
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_addr_wr] <= ram_din;
        if (ram_rd_en) ram_dout <= mem[ram_addr_rd];
    end

    int n_cmp = 0, n_mis = 0;
    int m_wptr, m_rptr;
    int m_vexp;
    logic [MW-1:0] m_dexp;
    logic [MW-1:0] ref_mem [256];
    logic [N-1:0] o_wg, o_rg, o_rv;
    logic [MW-1:0] o_rd;
    logic g1_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // first requester at or after ptr+1 (mod N), -1 if none
    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 1; k <= N; k++)
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_wptr = N - 1;
        m_rptr = N - 1;
        m_vexp = 0;
    endtask

    task automatic set_wr(input int i, input logic [AW-1:0] a, input logic [MW-1:0] d);
        wr_addr[i*AW +: AW] = a;
        wr_data[i*MW +: MW] = d;
    endtask

    // called just after a falling edge: check combinational and registered outputs, advance one clock
    task automatic cycle();
        int wi, ri;
        #1;
        wi = pick(wr_req, m_wptr);
        ri = pick(rd_req, m_rptr);
        o_wg = wr_gnt; o_rg = rd_gnt; o_rv = rd_valid; o_rd = rd_data;
        if (wr_gnt[1]) g1_seen = 1'b1;
        chk("wr_gnt", wr_gnt, wi < 0 ? 0 : 1 << wi);
        chk("rd_gnt", rd_gnt, ri < 0 ? 0 : 1 << ri);
        chk("ram_wr_en", ram_wr_en, wi >= 0);
        chk("ram_rd_en", ram_rd_en, ri >= 0);
        chk("ram_addr_wr", ram_addr_wr, wi < 0 ? 0 : wr_addr[wi*AW +: AW]);
        chk("ram_din", ram_din, wi < 0 ? 0 : wr_data[wi*MW +: MW]);
        chk("ram_addr_rd", ram_addr_rd, ri < 0 ? 0 : rd_addr[ri*AW +: AW]);
        chk("rd_valid", rd_valid, m_vexp);
        if (m_vexp != 0) chk("rd_data", rd_data, m_dexp);
        @(posedge clk);
        m_vexp = ri < 0 ? 0 : 1 << ri;
        if (ri >= 0) begin
            m_dexp = ref_mem[rd_addr[ri*AW +: AW]];
            m_rptr = ri;
        end
        if (wi >= 0) begin
            ref_mem[wr_addr[wi*AW +: AW]] = wr_data[wi*MW +: MW];
            m_wptr = wi;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [3:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_reset();
        g1_seen = 1'b0;

        // reset holds grants and enables low even with requests present
        @(negedge clk);
        wr_req = 4'b1111; rd_req = 4'b1111;
        #1;
        chk("rst_wr_gnt", wr_gnt, 0);
        chk("rst_rd_gnt", rd_gnt, 0);
        chk("rst_wr_en", ram_wr_en, 0);
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_rd_valid", rd_valid, 0);
        @(negedge clk);
        wr_req = '0; rd_req = '0; rst = 1'b0;

        // all four write continuously: strict rotation from requester 0
        for (int i = 0; i < N; i++) set_wr(i, AW'(8'h10 + i), MW'(8'hA0 + i));
        wr_req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("wr_seq", o_wg, seq[i]);
        end
        wr_req = '0;
        for (int i = 0; i < N; i++) chk("mem_init", mem[8'h10 + i], 8'hA0 + i);

        // single read: grant, then valid+data next cycle, then idle
        rd_addr[2*AW +: AW] = 8'h12; rd_req = 4'b0100;
        cycle();
        chk("rd2_gnt", o_rg, 4'b0100);
        rd_req = '0;
        cycle();
        chk("rd2_valid", o_rv, 4'b0100);
        chk("rd2_data", o_rd, 8'hA2);
        cycle();
        chk("rd2_idle", o_rv, 0);

        // write and read of the same address in one cycle return the old value
        set_wr(1, 8'h20, 8'h55); wr_req = 4'b0010;
        rd_addr[3*AW +: AW] = 8'h20; rd_req = 4'b1000;
        cycle();
        wr_req = '0;
        cycle();
        chk("coll_old", o_rd, 8'h00);
        rd_req = '0;
        cycle();
        chk("coll_new", o_rd, 8'h55);
        chk("coll_valid", o_rv, 4'b1000);

        // two readers alternate
        rd_addr[0 +: AW] = 8'h10; rd_addr[AW +: AW] = 8'h11; rd_req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("alt_gnt", o_rg, i % 2 == 0 ? 4'b0001 : 4'b0010);
        end
        rd_req = '0;
        cycle();

        // asynchronous reset right after a read grant
        set_wr(0, 8'h50, 8'h11); set_wr(3, 8'h53, 8'h33);
        rd_addr[0 +: AW] = 8'h13; rd_addr[3*AW +: AW] = 8'h11;
        wr_req = 4'b1001; rd_req = 4'b1001;
        cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", rd_valid, 0);
        chk("arst_wr_en", ram_wr_en, 0);
        chk("arst_rd_en", ram_rd_en, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        chk("arst_wr_win", o_wg, 4'b0001);
        chk("arst_rd_win", o_rg, 4'b0001);
        wr_req = '0; rd_req = '0;
        cycle();

        // requester 1 withdraws while requester 0 is served
        set_wr(3, 8'h60, 8'h66); wr_req = 4'b1000;
        cycle();
        g1_seen = 1'b0;
        set_wr(0, 8'h30, 8'h99); set_wr(1, 8'h31, 8'h77); wr_req = 4'b0011;
        cycle();
        chk("wd_r0", o_wg, 4'b0001);
        wr_req = 4'b0001;
        cycle();
        wr_req = '0;
        cycle();
        chk("wd_no_gnt", g1_seen, 0);
        chk("wd_mem", mem[8'h31], 8'h00);

        // random traffic on a narrow address window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            wr_req = N'($urandom);
            rd_req = N'($urandom);
            for (int i = 0; i < N; i++) begin
                set_wr(i, AW'(8'h40 + $urandom_range(0, 7)), MW'($urandom));
                rd_addr[i*AW +: AW] = AW'(8'h40 + $urandom_range(0, 7));
            end
            cycle();
        end
        wr_req = '0; rd_req = '0;
        cycle();
        for (int a = 8'h40; a < 8'h48; a++) chk("rand_mem", mem[a], ref_mem[a]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
